// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
//   Multi-cycle shift/logic/arithmetic ALU with optional 6502-style decimal
//   (BCD) ADC/SBC. Operands are captured on a start strobe. The binary result
//   is formed in EXEC, and decimal ADC/SBC take one extra ADJUST cycle. The
//   result and the N/Z/C/V flags are registered and announced by a one-cycle
//   done pulse.
//
// Parameters
//   WIDTH       datapath width (multiple of 4 when DECIMAL_EN=1)
//   DECIMAL_EN  1 = BCD adjust available, 0 = decimal_mode ignored
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    operation request, sampled only when idle
//   alu_op[3:0]              operation code
//   inputA, inputB           operands (accumulator side / memory side)
//   carry_in, overflow_in    current C and V flags
//   decimal_mode             current D flag
//   busy                     operation in flight
//   done                     one-cycle completion pulse
//   ALU_output               registered result
//   flag_n/z/c/v             registered flags
// ----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH      = 8,
   parameter bit DECIMAL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] inputA,
   input  logic [WIDTH-1:0] inputB,
   input  logic             carry_in,
   input  logic             overflow_in,
   input  logic             decimal_mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ALU_output,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int NIB = WIDTH / 4;

   localparam logic [3:0] OP_ASL  = 4'd0;
   localparam logic [3:0] OP_LSR  = 4'd1;
   localparam logic [3:0] OP_ROL  = 4'd2;
   localparam logic [3:0] OP_ROR  = 4'd3;
   localparam logic [3:0] OP_ADC  = 4'd4;
   localparam logic [3:0] OP_SBC  = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_ORA  = 4'd7;
   localparam logic [3:0] OP_EOR  = 4'd8;
   localparam logic [3:0] OP_INC  = 4'd9;
   localparam logic [3:0] OP_DEC  = 4'd10;
   localparam logic [3:0] OP_CMP  = 4'd11;
   localparam logic [3:0] OP_PASS = 4'd12;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ADJUST} state_t;

   state_t           state;
   logic [3:0]       op_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic             ci_p0;
   logic             vi_p0;
   logic             d_p0;

   logic             accept;
   logic             go_adjust;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] res_bin;
   logic             c_bin;
   logic             v_bin;
   logic [WIDTH:0]   dec_w;

   // Two's-complement overflow: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y,
                                    input logic signed [WIDTH-1:0] r);
      return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
   endfunction

   // Decimal add, nibble by nibble; the corrected nibble carry ripples upward.
   // Returns {carry, result}.
   function automatic logic [WIDTH:0] bcd_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
      logic [5:0]       s;
      logic             c;
      logic [WIDTH-1:0] r;
      c = cin;
      r = '0;
      for (int i = 0; i < NIB; i++) begin
         s = {2'b00, x[4*i +: 4]} + {2'b00, y[4*i +: 4]} + {5'b00000, c};
         if (s > 6'd9) s = s + 6'd6;
         c = (s > 6'd15);
         r[4*i +: 4] = s[3:0];
      end
      return {c, r};
   endfunction

   // Decimal subtract: a nibble that borrows is corrected by -6.
   // Returns {no_borrow, result}.
   function automatic logic [WIDTH:0] bcd_sub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
      logic [5:0]       d;
      logic             bw;
      logic [WIDTH-1:0] r;
      bw = ~cin;
      r  = '0;
      for (int i = 0; i < NIB; i++) begin
         d = {2'b00, x[4*i +: 4]} - {2'b00, y[4*i +: 4]} - {5'b00000, bw};
         if (d[5]) begin
            d  = d - 6'd6;
            bw = 1'b1;
         end else begin
            bw = 1'b0;
         end
         r[4*i +: 4] = d[3:0];
      end
      return {~bw, r};
   endfunction

   // The done cycle still belongs to the finishing operation, so a start
   // coinciding with done is not taken.
   assign accept    = (state == S_IDLE) && start && !done;
   assign go_adjust = DECIMAL_EN && d_p0 && ((op_p0 == OP_ADC) || (op_p0 == OP_SBC));

   // ---- stage p0: operand capture ----
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0 <= alu_op;
         a_p0  <= inputA;
         b_p0  <= inputB;
         ci_p0 <= carry_in;
         vi_p0 <= overflow_in;
         d_p0  <= decimal_mode;
      end
   end

   // ---- stage p1: binary result (EXEC) and decimal correction (ADJUST) ----
   always_comb begin
      b_eff   = ((op_p0 == OP_SBC) || (op_p0 == OP_CMP)) ? ~b_p0 : b_p0;
      cin_eff = (op_p0 == OP_CMP) ? 1'b1 : ci_p0;
      sum_w   = {1'b0, a_p0} + {1'b0, b_eff} + (WIDTH+1)'(cin_eff);
      res_bin = '0;
      c_bin   = ci_p0;
      v_bin   = vi_p0;
      case (op_p0)
         OP_ASL:  begin res_bin = {a_p0[WIDTH-2:0], 1'b0};  c_bin = a_p0[WIDTH-1]; end
         OP_LSR:  begin res_bin = {1'b0, a_p0[WIDTH-1:1]};  c_bin = a_p0[0];       end
         OP_ROL:  begin res_bin = {a_p0[WIDTH-2:0], ci_p0}; c_bin = a_p0[WIDTH-1]; end
         OP_ROR:  begin res_bin = {ci_p0, a_p0[WIDTH-1:1]}; c_bin = a_p0[0];       end
         OP_ADC, OP_SBC: begin
            res_bin = sum_w[WIDTH-1:0];
            c_bin   = sum_w[WIDTH];
            v_bin   = add_ovf(a_p0, b_eff, sum_w[WIDTH-1:0]);
         end
         OP_AND:  res_bin = a_p0 & b_p0;
         OP_ORA:  res_bin = a_p0 | b_p0;
         OP_EOR:  res_bin = a_p0 ^ b_p0;
         OP_INC:  res_bin = a_p0 + WIDTH'(1);
         OP_DEC:  res_bin = a_p0 - WIDTH'(1);
         OP_CMP:  begin res_bin = sum_w[WIDTH-1:0]; c_bin = sum_w[WIDTH]; end
         OP_PASS: res_bin = b_p0;
         default: res_bin = '0;
      endcase
      dec_w = (op_p0 == OP_SBC) ? bcd_sub(a_p0, b_p0, ci_p0)
                                : bcd_add(a_p0, b_p0, ci_p0);
   end

   // ---- stage p2: control FSM and registered result/flags ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         ALU_output <= '0;
         flag_n     <= 1'b0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_EXEC;
                  busy  <= 1'b1;
               end
            end
            S_EXEC: begin
               if (go_adjust) begin
                  state <= S_ADJUST;
               end else begin
                  ALU_output <= res_bin;
                  flag_n     <= res_bin[WIDTH-1];
                  flag_z     <= (res_bin == '0);
                  flag_c     <= c_bin;
                  flag_v     <= v_bin;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            S_ADJUST: begin
               // V comes from the binary sum; N/Z/C from the adjusted value.
               ALU_output <= dec_w[WIDTH-1:0];
               flag_n     <= dec_w[WIDTH-1];
               flag_z     <= (dec_w[WIDTH-1:0] == '0);
               flag_c     <= dec_w[WIDTH];
               flag_v     <= v_bin;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
//   Directed bench for alu_seq. Three instances: 8-bit with decimal support,
//   8-bit without decimal support, and 16-bit with decimal support. Expected
//   values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  op;
   logic [7:0]  a, b;
   logic [15:0] a16, b16;
   logic        ci, vi, dm;
   logic        st_d, st_b, st_w;

   logic        busy_d, done_d, n_d, z_d, c_d, v_d;
   logic [7:0]  out_d;
   logic        busy_b, done_b, n_b, z_b, c_b, v_b;
   logic [7:0]  out_b;
   logic        busy_w, done_w, n_w, z_w, c_w, v_w;
   logic [15:0] out_w;

   int tests = 0;
   int fails = 0;
   logic [7:0] last_d = 8'h00;
   logic [7:0] last_b = 8'h00;

   alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b1)) u_dec (
      .clk(clk), .rst(rst), .start(st_d), .alu_op(op), .inputA(a), .inputB(b),
      .carry_in(ci), .overflow_in(vi), .decimal_mode(dm),
      .busy(busy_d), .done(done_d), .ALU_output(out_d),
      .flag_n(n_d), .flag_z(z_d), .flag_c(c_d), .flag_v(v_d));

   alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b0)) u_bin (
      .clk(clk), .rst(rst), .start(st_b), .alu_op(op), .inputA(a), .inputB(b),
      .carry_in(ci), .overflow_in(vi), .decimal_mode(dm),
      .busy(busy_b), .done(done_b), .ALU_output(out_b),
      .flag_n(n_b), .flag_z(z_b), .flag_c(c_b), .flag_v(v_b));

   alu_seq #(.WIDTH(16), .DECIMAL_EN(1'b1)) u_w16 (
      .clk(clk), .rst(rst), .start(st_w), .alu_op(op), .inputA(a16), .inputB(b16),
      .carry_in(ci), .overflow_in(vi), .decimal_mode(dm),
      .busy(busy_w), .done(done_w), .ALU_output(out_w),
      .flag_n(n_w), .flag_z(z_w), .flag_c(c_w), .flag_v(v_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One operation on an 8-bit instance (sel 0 = decimal, 1 = binary-only).
   // nzcv is the expected {N,Z,C,V}.
   task automatic run8(input bit sel, input logic [3:0] o, input logic [7:0] xa,
                       input logic [7:0] xb, input logic xci, input logic xvi,
                       input logic xd, input int lat, input logic [7:0] er,
                       input logic [3:0] nzcv, input string tag);
      int   cnt;
      logic got;
      @(negedge clk);
      op = o; a = xa; b = xb; ci = xci; vi = xvi; dm = xd;
      if (sel) st_b = 1'b1; else st_d = 1'b1;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
         st_d = 1'b0;
         st_b = 1'b0;
         got = sel ? done_b : done_d;
         if (!got && cnt == 1) begin
            chk({tag, " busy"}, sel ? busy_b : busy_d, 1);
            chk({tag, " hold"}, sel ? out_b : out_d, sel ? last_b : last_d);
         end
      end
      chk({tag, " latency"}, cnt, lat);
      chk({tag, " result"}, sel ? out_b : out_d, er);
      chk({tag, " nzcv"}, sel ? {n_b, z_b, c_b, v_b} : {n_d, z_d, c_d, v_d}, nzcv);
      chk({tag, " busy at done"}, sel ? busy_b : busy_d, 0);
      @(posedge clk); #1;
      chk({tag, " single pulse"}, sel ? done_b : done_d, 0);
      if (sel) last_b = er; else last_d = er;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst = 1'b1; op = 4'd0; a = 8'h00; b = 8'h00; a16 = 16'h0; b16 = 16'h0;
      ci = 1'b0; vi = 1'b0; dm = 1'b0; st_d = 1'b0; st_b = 1'b0; st_w = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("reset dec", {busy_d, done_d, out_d, n_d, z_d, c_d, v_d}, 0);
      chk("reset bin", {busy_b, done_b, out_b, n_b, z_b, c_b, v_b}, 0);
      chk("reset w16", {busy_w, done_w, out_w, n_w, z_w, c_w, v_w}, 0);
      @(negedge clk); rst = 1'b0;

      // Shifts, arithmetic, logic
      run8(0, 4'd0,  8'h81, 8'h00, 0, 0, 0, 2, 8'h02, 4'b0010, "ASL");
      run8(0, 4'd4,  8'h7F, 8'h01, 0, 0, 0, 2, 8'h80, 4'b1001, "ADC bin");
      run8(0, 4'd4,  8'h58, 8'h46, 1, 0, 1, 3, 8'h05, 4'b0011, "ADC dec");
      run8(1, 4'd4,  8'h58, 8'h46, 1, 0, 1, 2, 8'h9F, 4'b1001, "ADC nodec");
      run8(0, 4'd5,  8'h10, 8'h01, 1, 0, 1, 3, 8'h09, 4'b0010, "SBC dec");
      run8(0, 4'd5,  8'h00, 8'h01, 1, 0, 1, 3, 8'h99, 4'b1000, "SBC dec borrow");
      run8(1, 4'd5,  8'h10, 8'h01, 1, 0, 1, 2, 8'h0F, 4'b0010, "SBC nodec");
      run8(0, 4'd5,  8'h00, 8'h01, 1, 0, 0, 2, 8'hFF, 4'b1000, "SBC bin");
      run8(0, 4'd1,  8'h01, 8'h00, 0, 1, 0, 2, 8'h00, 4'b0111, "LSR");
      run8(0, 4'd2,  8'h80, 8'h00, 1, 0, 0, 2, 8'h01, 4'b0010, "ROL");
      run8(0, 4'd8,  8'hFF, 8'h0F, 1, 0, 0, 2, 8'hF0, 4'b1010, "EOR");
      run8(0, 4'd10, 8'h00, 8'h00, 0, 0, 0, 2, 8'hFF, 4'b1000, "DEC wrap");
      run8(0, 4'd9,  8'hFF, 8'h00, 1, 0, 0, 2, 8'h00, 4'b0110, "INC wrap");
      run8(0, 4'd6,  8'hF0, 8'h3C, 0, 0, 0, 2, 8'h30, 4'b0000, "AND");
      run8(0, 4'd7,  8'h0F, 8'h30, 0, 1, 0, 2, 8'h3F, 4'b0001, "ORA");
      run8(0, 4'd12, 8'h12, 8'h80, 0, 0, 0, 2, 8'h80, 4'b1000, "PASS");
      run8(0, 4'd14, 8'h55, 8'hAA, 1, 1, 0, 2, 8'h00, 4'b0111, "RSVD");
      run8(0, 4'd3,  8'h02, 8'h00, 1, 0, 0, 2, 8'h81, 4'b1000, "ROR");

      // CMP with start held high: second request while busy and during
      // done is ignored, then accepted the cycle after done.
      @(negedge clk);
      op = 4'd11; a = 8'h10; b = 8'h10; ci = 1'b0; vi = 1'b1; dm = 1'b0; st_d = 1'b1;
      @(posedge clk); #1;
      chk("CMP busy", busy_d, 1);
      op = 4'd0; a = 8'h81; b = 8'h00;
      @(posedge clk); #1;
      chk("CMP done", done_d, 1);
      chk("CMP result", out_d, 8'h00);
      chk("CMP nzcv", {n_d, z_d, c_d, v_d}, 4'b0111);
      @(posedge clk); #1;
      chk("CMP start on done ignored", {busy_d, done_d}, 2'b00);
      @(posedge clk); #1;
      chk("b2b accepted", busy_d, 1);
      st_d = 1'b0;
      @(posedge clk); #1;
      chk("b2b done", done_d, 1);
      chk("b2b result", out_d, 8'h02);
      chk("b2b nzcv", {n_d, z_d, c_d, v_d}, 4'b0011);
      @(posedge clk); #1;
      chk("b2b single pulse", done_d, 0);
      last_d = 8'h02;

      // 16-bit ROR
      @(negedge clk);
      op = 4'd3; a16 = 16'h0001; b16 = 16'h0000; ci = 1'b1; vi = 1'b0; dm = 1'b0; st_w = 1'b1;
      @(posedge clk); #1;
      st_w = 1'b0;
      chk("W16 ROR early", {busy_w, done_w}, 2'b10);
      @(posedge clk); #1;
      chk("W16 ROR done", done_w, 1);
      chk("W16 ROR result", out_w, 16'h8000);
      chk("W16 ROR nzcv", {n_w, z_w, c_w, v_w}, 4'b1010);

      // Asynchronous reset during ADJUST
      @(negedge clk);
      op = 4'd4; a = 8'h58; b = 8'h46; ci = 1'b1; vi = 1'b0; dm = 1'b1; st_d = 1'b1;
      @(posedge clk); #1;
      st_d = 1'b0;
      @(posedge clk); #1;
      chk("ADJ in flight", {busy_d, done_d}, 2'b10);
      rst = 1'b1;
      #1;
      chk("async reset", {busy_d, done_d, out_d, n_d, z_d, c_d, v_d}, 0);
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done_d) seen = 1'b1;
      end
      chk("no done after abort", seen, 0);
      last_d = 8'h00;
      run8(0, 4'd4, 8'h58, 8'h46, 1, 0, 1, 3, 8'h05, 4'b0011, "ADC dec after reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
